// File: rtl/ss_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ss_seq_pkg
//  Purpose  : Shared types and constants for the save-state sequencer:
//             FSM state encoding, header word layout and the bus address
//             step per 64-bit word.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ss_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START_WAIT = 3'd1,
        ST_FETCH      = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_WAIT_ACK   = 3'd4,
        ST_APPLY      = 3'd5,
        ST_NEXT       = 3'd6,
        ST_FINISH     = 3'd7
    } seq_state_t;

    // The save-state bus addresses 32-bit units, so each 64-bit word is 2 apart.
    localparam int ADDR_STEP = 2;

    // Header word: {magic[31:0], 16'h0, word_count[15:0]}
    localparam int HDR_MAGIC_LSB = 32;
    localparam int HDR_MAGIC_W   = 32;
    localparam int HDR_COUNT_LSB = 0;
    localparam int HDR_COUNT_W   = 16;

    function automatic logic [63:0] make_header(input logic [31:0] magic,
                                                input logic [15:0] count);
        logic [63:0] word;
        word = '0;
        word[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
        word[HDR_COUNT_LSB +: HDR_COUNT_W] = count;
        return word;
    endfunction

endpackage : ss_seq_pkg
`default_nettype wire

// File: rtl/ss_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ss_state_sequencer
//  Purpose  : Initiator on the core save-state bus. A rising edge on ss_save
//             streams a header word plus WORD_COUNT core slots to the
//             controller; a rising edge on ss_load reads them back, checks
//             the header and writes the slots into the core.
//  Ports    : clk_ppu_21_47 / reset_n      clock, async active-low reset
//             ss_save / ss_load            operation triggers (edge)
//             ss_req/rnw/addr/dout/be      request side of the bus
//             ss_din / ss_ack              completion side of the bus
//             ss_busy                      operation in progress
//             slot_addr/rd_data/wr_en/wr_data  core state slot access
//             op_done / op_err             completion pulse / sticky error
//  Revision : 1.0  initial release
// ============================================================================
module ss_state_sequencer
    import ss_seq_pkg::*;
#(
    parameter int unsigned  WORD_COUNT  = 64,
    parameter logic [25:0]  BASE_ADDR   = 26'h0,
    parameter logic [31:0]  MAGIC       = 32'h4E45_5353,
    parameter int unsigned  START_DELAY = 6,
    parameter int unsigned  ACK_TIMEOUT = 4096
) (
    input  logic        clk_ppu_21_47,
    input  logic        reset_n,
    input  logic        ss_save,
    input  logic        ss_load,
    output logic        ss_req,
    output logic        ss_rnw,
    output logic [25:0] ss_addr,
    output logic [63:0] ss_dout,
    output logic [7:0]  ss_be,
    input  logic [63:0] ss_din,
    input  logic        ss_ack,
    output logic        ss_busy,
    output logic [15:0] slot_addr,
    input  logic [63:0] slot_rd_data,
    output logic        slot_wr_en,
    output logic [63:0] slot_wr_data,
    output logic        op_done,
    output logic        op_err
);

    localparam logic [15:0] c_word_last  = 16'(WORD_COUNT);
    localparam logic [12:0] c_timeout    = 13'(ACK_TIMEOUT);
    localparam logic [15:0] c_delay_last = (START_DELAY == 0) ? 16'd0 : 16'(START_DELAY - 1);
    localparam logic [25:0] c_addr_step  = 26'(ADDR_STEP);
    localparam logic [63:0] c_header     = make_header(MAGIC, c_word_last);

    seq_state_t  r_state;
    seq_state_t  w_next;

    logic        r_prev_save;
    logic        r_prev_load;
    logic        r_op;            // 1 = load, 0 = save
    logic [15:0] r_idx;           // word index, 0 = header
    logic [15:0] r_delay;
    logic [12:0] r_to;
    logic        r_fetch_wait;    // first FETCH cycle gives the slot read time to settle
    logic [25:0] r_addr;
    logic [63:0] r_dout;
    logic [63:0] r_capture;
    logic [15:0] r_slot_addr;
    logic        r_err;

    logic        w_save_edge;
    logic        w_load_edge;
    logic        w_timeout;
    logic        w_last;
    logic        w_hdr_bad;

    assign w_save_edge = ss_save & ~r_prev_save;
    assign w_load_edge = ss_load & ~r_prev_load;
    assign w_timeout   = !ss_ack && ((r_to + 13'd1) == c_timeout);
    assign w_last      = (r_idx == c_word_last);
    assign w_hdr_bad   = (r_capture != c_header);

    assign ss_rnw       = r_op;
    assign ss_addr      = r_addr;
    assign ss_dout      = r_dout;
    assign slot_addr    = r_slot_addr;
    assign slot_wr_data = r_capture;
    assign op_err       = r_err;

    always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ss_req     = 1'b0;
        ss_be      = 8'h00;
        ss_busy    = 1'b1;
        slot_wr_en = 1'b0;
        op_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ss_busy = 1'b0;
                if (w_save_edge || w_load_edge) begin
                    w_next = ST_START_WAIT;
                end
            end
            ST_START_WAIT: begin
                if (r_delay == c_delay_last) begin
                    w_next = r_op ? ST_ISSUE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if ((r_idx == 16'd0) || r_fetch_wait) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ss_req = 1'b1;
                ss_be  = 8'hFF;
                w_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                ss_be = 8'hFF;
                if (ss_ack) begin
                    w_next = r_op ? ST_APPLY : ST_NEXT;
                end else if (w_timeout) begin
                    w_next = ST_FINISH;
                end
            end
            ST_APPLY: begin
                if (r_idx == 16'd0) begin
                    w_next = w_hdr_bad ? ST_FINISH : ST_NEXT;
                end else begin
                    slot_wr_en = 1'b1;
                    w_next     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_last) begin
                    w_next = ST_FINISH;
                end else begin
                    w_next = r_op ? ST_ISSUE : ST_FETCH;
                end
            end
            ST_FINISH: begin
                ss_busy = 1'b0;
                op_done = !r_err;
                w_next  = ST_IDLE;
            end
            default: begin
                ss_busy = 1'b0;
                w_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ppu_21_47 or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_save  <= 1'b0;
            r_prev_load  <= 1'b0;
            r_op         <= 1'b0;
            r_idx        <= 16'd0;
            r_delay      <= 16'd0;
            r_to         <= 13'd0;
            r_fetch_wait <= 1'b0;
            r_addr       <= 26'd0;
            r_dout       <= 64'd0;
            r_capture    <= 64'd0;
            r_slot_addr  <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            r_prev_save <= ss_save;
            r_prev_load <= ss_load;
            case (r_state)
                ST_IDLE: begin
                    if (w_save_edge || w_load_edge) begin
                        r_op         <= w_load_edge;   // load wins a tie
                        r_idx        <= 16'd0;
                        r_delay      <= 16'd0;
                        r_fetch_wait <= 1'b0;
                        r_addr       <= BASE_ADDR;
                        r_slot_addr  <= 16'd0;
                        r_err        <= 1'b0;
                    end
                end
                ST_START_WAIT: begin
                    r_delay <= r_delay + 16'd1;
                end
                ST_FETCH: begin
                    if (r_idx == 16'd0) begin
                        r_dout <= c_header;
                    end else if (!r_fetch_wait) begin
                        r_fetch_wait <= 1'b1;
                    end else begin
                        r_dout       <= slot_rd_data;
                        r_fetch_wait <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_to <= 13'd0;
                end
                ST_WAIT_ACK: begin
                    if (ss_ack) begin
                        if (r_op) begin
                            r_capture <= ss_din;
                        end
                    end else begin
                        r_to <= r_to + 13'd1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_APPLY: begin
                    if ((r_idx == 16'd0) && w_hdr_bad) begin
                        r_err <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (!w_last) begin
                        r_idx       <= r_idx + 16'd1;
                        r_addr      <= r_addr + c_addr_step;
                        r_slot_addr <= r_idx;          // slot of the next word is i-1
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : ss_state_sequencer
`default_nettype wire

// File: tb/tb_ss_state_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ss_state_sequencer
//  Purpose  : Directed self-checking bench for ss_state_sequencer with a
//             4-word image, a controller model acking 3 cycles after each
//             request and a registered-read slot memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ss_state_sequencer;

    localparam logic [63:0] HDR_OK  = 64'h4E45_5353_0000_0004;
    localparam logic [63:0] HDR_BAD = 64'hDEAD_BEEF_0000_0004;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ss_save;
    logic        ss_load;
    logic        ss_req;
    logic        ss_rnw;
    logic [25:0] ss_addr;
    logic [63:0] ss_dout;
    logic [7:0]  ss_be;
    logic [63:0] ss_din = 64'd0;
    logic        ss_ack = 1'b0;
    logic        ss_busy;
    logic [15:0] slot_addr;
    logic [63:0] slot_rd_data = 64'd0;
    logic        slot_wr_en;
    logic [63:0] slot_wr_data;
    logic        op_done;
    logic        op_err;

    always #5 clk = ~clk;

    ss_state_sequencer #(
        .WORD_COUNT  (4),
        .BASE_ADDR   (26'h0),
        .MAGIC       (32'h4E45_5353),
        .START_DELAY (6),
        .ACK_TIMEOUT (4096)
    ) dut (
        .clk_ppu_21_47 (clk),
        .reset_n       (reset_n),
        .ss_save       (ss_save),
        .ss_load       (ss_load),
        .ss_req        (ss_req),
        .ss_rnw        (ss_rnw),
        .ss_addr       (ss_addr),
        .ss_dout       (ss_dout),
        .ss_be         (ss_be),
        .ss_din        (ss_din),
        .ss_ack        (ss_ack),
        .ss_busy       (ss_busy),
        .slot_addr     (slot_addr),
        .slot_rd_data  (slot_rd_data),
        .slot_wr_en    (slot_wr_en),
        .slot_wr_data  (slot_wr_data),
        .op_done       (op_done),
        .op_err        (op_err)
    );

    logic [63:0] slots [0:3];
    logic [63:0] img   [0:7];
    bit          ack_en = 1'b1;
    int          ack_dn = 0;
    int          pend_idx = 0;

    // monitor state
    int          n_req, n_ack, n_wr, n_done, n_overlap, cyc, first_req_cyc, fall_cyc, acks_at_fall;
    logic        prev_busy = 1'b0;
    logic [25:0] req_addr [0:15];
    logic        req_rnw  [0:15];
    logic [63:0] req_dout [0:15];
    logic [7:0]  req_be   [0:15];
    logic [15:0] wr_addr  [0:15];
    logic [63:0] wr_data  [0:15];

    int          n_checks = 0;
    int          n_err    = 0;

    // Core slot memory: registered read.
    always @(posedge clk) slot_rd_data <= slots[slot_addr[1:0]];

    // Monitor first (sees the current cycle's values), then controller model.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ss_req) begin
            if (n_req == 0) first_req_cyc = cyc;
            if (n_req < 16) begin
                req_addr[n_req] = ss_addr;
                req_rnw[n_req]  = ss_rnw;
                req_dout[n_req] = ss_dout;
                req_be[n_req]   = ss_be;
            end
            n_req = n_req + 1;
        end
        if (ss_ack) n_ack = n_ack + 1;
        if (ss_req && ss_ack) n_overlap = n_overlap + 1;
        if (slot_wr_en) begin
            if (n_wr < 16) begin
                wr_addr[n_wr] = slot_addr;
                wr_data[n_wr] = slot_wr_data;
            end
            n_wr = n_wr + 1;
        end
        if (op_done) n_done = n_done + 1;
        if (prev_busy && !ss_busy) begin
            acks_at_fall = n_ack;
            fall_cyc     = cyc;
        end
        prev_busy = ss_busy;

        ss_ack = 1'b0;
        if (!reset_n) begin
            ack_dn = 0;
        end else begin
            if (ack_dn > 0) begin
                ack_dn = ack_dn - 1;
                if (ack_dn == 0) begin
                    ss_ack = 1'b1;
                    ss_din = img[pend_idx];
                end
            end
            if (ss_req && ack_en) begin
                ack_dn   = 3;
                pend_idx = int'(ss_addr[3:1]);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        n_req = 0; n_ack = 0; n_wr = 0; n_done = 0; n_overlap = 0;
        cyc = 0; first_req_cyc = -1; fall_cyc = -1; acks_at_fall = -1;
    endtask

    // Raise the selected trigger(s) and verify ss_busy the cycle after.
    task automatic trigger(input bit do_save, input bit do_load, input string tag);
        @(negedge clk);
        check({tag, "_idle_before"}, 64'(ss_busy), 64'd0);
        if (do_save) ss_save = 1'b1;
        if (do_load) ss_load = 1'b1;
        @(negedge clk);
        check({tag, "_busy_rise"}, 64'(ss_busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (ss_busy && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        if (ss_busy) check({tag, "_done_timeout"}, 64'(ss_busy), 64'd0);
        ss_save = 1'b0;
        ss_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_reqs(input int want, input string tag);
        int k;
        k = 0;
        while (n_req < want && k < 200) begin
            @(negedge clk);
            k = k + 1;
        end
        if (n_req < want) check({tag, "_req_wait_timeout"}, 64'(n_req), 64'(want));
    endtask

    task automatic set_good_image();
        img[0] = HDR_OK;
        img[1] = 64'hCAFE_0000_0000_0001;
        img[2] = 64'hCAFE_0000_0000_0002;
        img[3] = 64'hCAFE_0000_0000_0003;
        img[4] = 64'hCAFE_0000_0000_0004;
    endtask

    task automatic check_save_stream(input string tag);
        logic [63:0] exp_data [0:4];
        exp_data[0] = HDR_OK;
        for (int i = 1; i < 5; i++) exp_data[i] = slots[i-1];
        check({tag, "_nreq"}, 64'(n_req), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(req_addr[i]), 64'(2 * i));
            check($sformatf("%s_rnw%0d", tag, i), 64'(req_rnw[i]), 64'd0);
            check($sformatf("%s_data%0d", tag, i), req_dout[i], exp_data[i]);
        end
        check({tag, "_be"}, 64'(req_be[0]), 64'hFF);
        check({tag, "_overlap"}, 64'(n_overlap), 64'd0);
        check({tag, "_done"}, 64'(n_done), 64'd1);
        check({tag, "_err"}, 64'(op_err), 64'd0);
    endtask

    task automatic check_load_stream(input string tag);
        check({tag, "_nreq"}, 64'(n_req), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s_rnw%0d", tag, i), 64'(req_rnw[i]), 64'd1);
        check({tag, "_nwr"}, 64'(n_wr), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_wraddr%0d", tag, i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("%s_wrdata%0d", tag, i), wr_data[i], img[i+1]);
        end
        check({tag, "_err"}, 64'(op_err), 64'd0);
        check({tag, "_done"}, 64'(n_done), 64'd1);
    endtask

    initial begin
        slots[0] = 64'h11; slots[1] = 64'h22; slots[2] = 64'h33; slots[3] = 64'h44;
        for (int i = 0; i < 8; i++) img[i] = 64'd0;
        set_good_image();
        reset_n = 1'b0;
        ss_save = 1'b0;
        ss_load = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_req",    64'(ss_req),     64'd0);
        check("rst_busy",   64'(ss_busy),    64'd0);
        check("rst_addr",   64'(ss_addr),    64'd0);
        check("rst_dout",   ss_dout,         64'd0);
        check("rst_be",     64'(ss_be),      64'd0);
        check("rst_rnw",    64'(ss_rnw),     64'd0);
        check("rst_wr_en",  64'(slot_wr_en), 64'd0);
        check("rst_slot",   64'(slot_addr),  64'd0);
        check("rst_wrdata", slot_wr_data,    64'd0);
        check("rst_done",   64'(op_done),    64'd0);
        check("rst_err",    64'(op_err),     64'd0);
        reset_n = 1'b1;

        // ---- save ----
        clear_mon();
        trigger(1'b1, 1'b0, "save");
        wait_done("save", 500);
        check_save_stream("save");
        check("save_fall_after_ack5", 64'(acks_at_fall), 64'd5);

        // ---- load, valid image ----
        clear_mon();
        trigger(1'b0, 1'b1, "load");
        wait_done("load", 500);
        check_load_stream("load");

        // ---- load, bad header ----
        img[0] = HDR_BAD;
        clear_mon();
        trigger(1'b0, 1'b1, "badhdr");
        wait_done("badhdr", 500);
        check("badhdr_nreq", 64'(n_req),   64'd1);
        check("badhdr_nwr",  64'(n_wr),    64'd0);
        check("badhdr_err",  64'(op_err),  64'd1);
        check("badhdr_busy", 64'(ss_busy), 64'd0);
        check("badhdr_done", 64'(n_done),  64'd0);
        img[0] = HDR_OK;

        // ---- ack timeout, then recovery ----
        ack_en = 1'b0;
        clear_mon();
        trigger(1'b1, 1'b0, "tmo");
        wait_done("tmo", 6000);
        check("tmo_err",   64'(op_err),  64'd1);
        check("tmo_busy",  64'(ss_busy), 64'd0);
        check("tmo_nreq",  64'(n_req),   64'd1);
        check("tmo_done",  64'(n_done),  64'd0);
        check("tmo_window", 64'((fall_cyc - first_req_cyc) >= 4096 && (fall_cyc - first_req_cyc) <= 4100), 64'd1);
        ack_en = 1'b1;
        clear_mon();
        trigger(1'b1, 1'b0, "resave");
        wait_done("resave", 500);
        check_save_stream("resave");

        // ---- simultaneous edges: load wins; save edge mid-load ignored ----
        clear_mon();
        trigger(1'b1, 1'b1, "both");
        wait_reqs(2, "both");
        ss_save = 1'b0;
        @(negedge clk);
        ss_save = 1'b1;
        while (ss_busy && cyc < 500) @(negedge clk);
        repeat (20) @(negedge clk);
        check("both_idle_after", 64'(ss_busy), 64'd0);
        wait_done("both", 10);
        check_load_stream("both");

        // ---- async reset during WAIT_ACK of word 2 ----
        clear_mon();
        trigger(1'b0, 1'b1, "rstmid");
        wait_reqs(3, "rstmid");
        ss_load = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_busy",  64'(ss_busy),    64'd0);
        check("rstmid_req",   64'(ss_req),     64'd0);
        check("rstmid_addr",  64'(ss_addr),    64'd0);
        check("rstmid_be",    64'(ss_be),      64'd0);
        check("rstmid_wr_en", 64'(slot_wr_en), 64'd0);
        check("rstmid_slot",  64'(slot_addr),  64'd0);
        check("rstmid_rnw",   64'(ss_rnw),     64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        check("rstmid_nwr_after",  64'(n_wr),    64'd0);
        check("rstmid_nreq_after", 64'(n_req),   64'd0);
        clear_mon();
        trigger(1'b1, 1'b0, "postrst");
        wait_done("postrst", 500);
        check_save_stream("postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ss_state_sequencer
`default_nettype wire

// File: doc/ss_state_sequencer.md
Name: ss_state_sequencer

Overview:
- Initiator side of the core save-state bus (ss_req/ss_rnw/ss_addr/ss_ack).
- On ss_save it walks a bank of core state slots and streams them as 64-bit words to the save-state controller. On ss_load it requests the same words back and writes them into the core.
- Sits between the NES core state registers and the PSRAM-backed save-state controller, in the clk_ppu_21_47 domain.

Parameters:
- WORD_COUNT, 64: number of 64-bit core state slots (1..65535).
- BASE_ADDR, 26'h0: ss_addr of the header word.
- MAGIC, 32'h4E45_5353: header signature.
- START_DELAY, 6: cycles from trigger edge to the first ss_req; lets the controller reach its request-wait state.
- ACK_TIMEOUT, 4096: cycles without ss_ack before abort.

Ports:
- clk_ppu_21_47  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ss_save  in  1  save trigger; rising edge starts a save.
- ss_load  in  1  load trigger; rising edge starts a load.
- ss_req  out  1  one-cycle transaction request pulse.
- ss_rnw  out  1  1 = read from controller (load), 0 = write (save).
- ss_addr  out  26  word address; advances by 2 per 64-bit word.
- ss_dout  out  64  save data to controller.
- ss_be  out  8  byte enables; always 8'hFF during a transaction.
- ss_din  in  64  load data from controller; valid when ss_ack = 1.
- ss_ack  in  1  one-cycle completion pulse from controller.
- ss_busy  out  1  high for the whole operation; its falling edge tells the controller the operation is done.
- slot_addr  out  16  core slot index.
- slot_rd_data  in  64  slot contents; valid 1 cycle after slot_addr changes.
- slot_wr_en  out  1  one-cycle write strobe into the core slot.
- slot_wr_data  out  64  data for the slot write.
- op_done  out  1  one-cycle pulse on successful completion.
- op_err  out  1  sticky error flag; cleared at the next trigger.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Asserting reset mid-operation aborts immediately; no further slot writes or requests occur.
- Trigger detection:
  - Both triggers are edge-detected with a registered previous value.
  - Edges are honoured only in IDLE.
  - If both edges occur in the same cycle, load wins.
  - ss_busy rises the cycle after the accepted edge.
- Word stream:
  - Word index i runs 0..WORD_COUNT. Word 0 is the header; word i≥1 is slot i-1.
  - ss_addr = BASE_ADDR + 2*i (26-bit arithmetic, wraps silently).
  - Header word = {MAGIC, 16'h0, WORD_COUNT[15:0]}.
- FSM states:
  - IDLE: wait for a trigger edge.
  - START_WAIT: count START_DELAY cycles, then go to FETCH (save) or ISSUE (load).
  - FETCH (save only, i≥1): drive slot_addr = i-1, wait 1 cycle, register slot_rd_data into ss_dout. For the header, ss_dout is loaded directly.
  - ISSUE: ss_req = 1 for exactly one cycle, with ss_rnw = op, ss_be = FF. ss_addr, ss_dout and ss_rnw stay stable from ISSUE until ack.
  - WAIT_ACK: wait for ss_ack.
    - On load, capture ss_din in the ack cycle.
    - If the timeout counter reaches ACK_TIMEOUT: set op_err, go to FINISH.
  - APPLY (load only):
    - i = 0: compare the captured word to the header. On mismatch set op_err and go to FINISH with no slot writes.
    - i ≥ 1: slot_wr_en pulse with slot_addr = i-1 and slot_wr_data = captured word.
  - NEXT: if i == WORD_COUNT go to FINISH; otherwise increment i and go to FETCH/ISSUE.
  - FINISH: ss_busy = 0; op_done pulses if op_err = 0; return to IDLE.
- ss_req spacing: the next ss_req is issued no earlier than 1 cycle after the cycle in which ss_ack was observed. ss_req is never high in an ack cycle, so the controller cannot double-count a request.
- ss_ack outside WAIT_ACK is ignored.
- ss_save/ss_load edges while busy are ignored.
- The timeout counter is 13 bits and resets at each ISSUE.
- Total transactions per operation = WORD_COUNT+1.

Decomposition:
- Package ss_seq_pkg holds the FSM state enum, the header layout localparams (magic position, count field) and the ADDR_STEP = 2 constant.
- No sub-module. The edge detectors and timeout counter stay inline.

Test Plan:
- Save, WORD_COUNT=4, slots = 64'h11..44, controller model acks 3 cycles after each req:
  - exactly 5 single-cycle reqs, all with rnw=0;
  - addr 0,2,4,6,8;
  - data = header {4E455353,0000,0004} followed by the slot values in order;
  - ss_busy falls after the 5th ack; op_done pulses.
- Load with a valid image: 5 reqs with rnw=1, 4 slot_wr_en pulses at slot_addr 0..3 carrying the model data; op_err = 0.
- Load with a bad header (magic 32'hDEADBEEF): 1 req, zero slot_wr_en, op_err = 1, ss_busy drops, no op_done.
- Model never acks: op_err = 1 after 4096 cycles, ss_busy = 0, FSM returns to IDLE; a subsequent save succeeds.
- ss_save and ss_load rise in the same cycle: load executes. A second ss_save edge mid-load is ignored.
- reset_n asserted during WAIT_ACK of word 2: all outputs 0 asynchronously; no slot_wr_en after release; the next trigger starts from word 0.
